// File: rtl/note_arbiter.sv
// Buzzer note arbiter: three held keys compete with an 8-step auto-melody for the
// buzzer divider, plus a saturating volume level that runs independently of the FSM.
//
// state    | meaning
// IDLE     | nothing sounding; arbitrate keys first, then the melody
// KEY      | a key owns the buzzer until its own request bit drops
// MEL_NOTE | melody step sounding for NOTE_TICKS ticks
// MEL_GAP  | silent gap of GAP_TICKS ticks between melody steps
module note_arbiter #(
  parameter int DIV_DO     = 153257,
  parameter int DIV_RE     = 136519,
  parameter int DIV_MI     = 121212,
  parameter int NOTE_TICKS = 25,
  parameter int GAP_TICKS  = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic [2:0]  key_req,
  input  logic        play_en,
  input  logic        vol_up,
  input  logic        vol_dn,
  output logic [19:0] note_div,
  output logic [3:0]  grant,
  output logic [3:0]  level,
  output logic [2:0]  step
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] KEY      = 2'd1;
  localparam logic [1:0] MEL_NOTE = 2'd2;
  localparam logic [1:0] MEL_GAP  = 2'd3;

  localparam logic [19:0] D_DO    = 20'(DIV_DO);
  localparam logic [19:0] D_RE    = 20'(DIV_RE);
  localparam logic [19:0] D_MI    = 20'(DIV_MI);
  localparam logic [7:0]  NOTE_LD = 8'(NOTE_TICKS);
  localparam logic [7:0]  GAP_LD  = 8'(GAP_TICKS);

  logic [1:0] state;
  logic [7:0] cnt;
  logic       key_any;
  logic       key_held;
  logic       tick_last;
  logic [2:0] step_nxt;
  logic [3:0] key_gnt;

  function automatic logic [3:0] key_grant(input logic [2:0] k);
    if (k[0])      return 4'b0001;
    else if (k[1]) return 4'b0010;
    else if (k[2]) return 4'b0100;
    else           return 4'b0000;
  endfunction

  function automatic logic [19:0] key_div(input logic [3:0] g);
    case (g)
      4'b0001: return D_DO;
      4'b0010: return D_RE;
      4'b0100: return D_MI;
      default: return 20'd0;
    endcase
  endfunction

  // Fixed tune: Do Re Mi Do Mi Re Do, then a rest that still holds the melody grant.
  function automatic logic [19:0] mel_div(input logic [2:0] s);
    case (s)
      3'd0, 3'd3, 3'd6: return D_DO;
      3'd1, 3'd5:       return D_RE;
      3'd2, 3'd4:       return D_MI;
      default:          return 20'd0;
    endcase
  endfunction

  assign key_any   = |key_req;
  assign key_held  = |(grant[2:0] & key_req);
  assign tick_last = tick && (cnt <= 8'd1);
  assign step_nxt  = step + 3'd1;
  assign key_gnt   = key_grant(key_req);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= 8'd0;
      step     <= 3'd0;
      note_div <= 20'd0;
      grant    <= 4'b0000;
    end else begin
      case (state)
        IDLE: begin
          if (key_any) begin
            state    <= KEY;
            grant    <= key_gnt;
            note_div <= key_div(key_gnt);
          end else if (play_en) begin
            state    <= MEL_NOTE;
            cnt      <= NOTE_LD;
            grant    <= 4'b1000;
            note_div <= mel_div(step);
          end else begin
            grant    <= 4'b0000;
            note_div <= 20'd0;
          end
        end
        KEY: begin
          if (!play_en) step <= 3'd0;
          if (!key_held) begin
            state    <= IDLE;
            grant    <= 4'b0000;
            note_div <= 20'd0;
          end
        end
        MEL_NOTE, MEL_GAP: begin
          // Exits outrank the tick: a tick arriving with a key or play_en drop is dropped.
          if (key_any) begin
            state    <= KEY;
            grant    <= key_gnt;
            note_div <= key_div(key_gnt);
            if (!play_en) step <= 3'd0;
          end else if (!play_en) begin
            state    <= IDLE;
            step     <= 3'd0;
            grant    <= 4'b0000;
            note_div <= 20'd0;
          end else if (tick) begin
            if (!tick_last) begin
              cnt <= cnt - 8'd1;
            end else if (state == MEL_NOTE) begin
              state    <= MEL_GAP;
              cnt      <= GAP_LD;
              grant    <= 4'b0000;
              note_div <= 20'd0;
            end else begin
              state    <= MEL_NOTE;
              cnt      <= NOTE_LD;
              step     <= step_nxt;
              grant    <= 4'b1000;
              note_div <= mel_div(step_nxt);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level <= 4'd8;
    end else if (vol_up && !vol_dn && level != 4'd15) begin
      level <= level + 4'd1;
    end else if (vol_dn && !vol_up && level != 4'd0) begin
      level <= level - 4'd1;
    end
  end

endmodule

// File: tb/tb_note_arbiter.sv
// Directed bench for note_arbiter: vector table for key arbitration and volume,
// hand sequences for melody timing, preemption/resume and async reset.
module tb_note_arbiter;

  localparam logic [19:0] DO = 20'd153257;
  localparam logic [19:0] RE = 20'd136519;
  localparam logic [19:0] MI = 20'd121212;

  logic        clk;
  logic        reset;
  logic        tick;
  logic [2:0]  key_req;
  logic        play_en;
  logic        vol_up;
  logic        vol_dn;
  logic [19:0] note_div;
  logic [3:0]  grant;
  logic [3:0]  level;
  logic [2:0]  step;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_level;

  typedef struct {
    logic [2:0]  key;
    logic        play;
    logic        tk;
    logic        up;
    logic        dn;
    logic [19:0] div;
    logic [3:0]  gnt;
    logic [3:0]  lvl;
    logic [2:0]  stp;
  } vec_t;

  vec_t vecs[$];

  note_arbiter #(
    .DIV_DO(153257), .DIV_RE(136519), .DIV_MI(121212),
    .NOTE_TICKS(2), .GAP_TICKS(1)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .key_req(key_req), .play_en(play_en),
    .vol_up(vol_up), .vol_dn(vol_dn), .note_div(note_div), .grant(grant),
    .level(level), .step(step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [19:0] mel(input int s);
    case (s % 8)
      0, 3, 6: return DO;
      1, 5:    return RE;
      2, 4:    return MI;
      default: return 20'd0;
    endcase
  endfunction

  task automatic check(input string name, input logic [19:0] e_div, input logic [3:0] e_gnt,
                       input logic [3:0] e_lvl, input logic [2:0] e_stp);
    checks++;
    if (note_div !== e_div || grant !== e_gnt || level !== e_lvl || step !== e_stp) begin
      errors++;
      $display("FAIL %s: got div=%0d grant=%b level=%0d step=%0d, want div=%0d grant=%b level=%0d step=%0d",
               name, note_div, grant, level, step, e_div, e_gnt, e_lvl, e_stp);
    end
  endtask

  task automatic cyc(input logic [2:0] k, input logic p, input logic t,
                     input logic u, input logic d);
    key_req = k; play_en = p; tick = t; vol_up = u; vol_dn = d;
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input logic [2:0] k, input logic p, input logic t, input logic u,
                         input logic d, input logic [19:0] dv, input logic [3:0] g,
                         input logic [3:0] l, input logic [2:0] s);
    vec_t v;
    v.key = k; v.play = p; v.tk = t; v.up = u; v.dn = d;
    v.div = dv; v.gnt = g; v.lvl = l; v.stp = s;
    vecs.push_back(v);
  endtask

  // One melody step with a tick every 4th clk: 8 clk of note, 4 clk of gap, next note.
  task automatic mel_step(input int s);
    logic [19:0] e_div;
    logic [3:0]  e_gnt;
    logic [2:0]  e_stp;
    for (int c = 1; c <= 12; c++) begin
      cyc(3'b000, 1'b1, (c % 4) == 0, 1'b0, 1'b0);
      if (c < 8)       begin e_div = mel(s);     e_gnt = 4'b1000; e_stp = 3'(s); end
      else if (c < 12) begin e_div = 20'd0;      e_gnt = 4'b0000; e_stp = 3'(s); end
      else             begin e_div = mel(s + 1); e_gnt = 4'b1000; e_stp = 3'((s + 1) % 8); end
      check($sformatf("mel_s%0d_c%0d", s, c), e_div, e_gnt, exp_level, e_stp);
    end
  endtask

  initial begin
    int l;
    reset = 1'b1; tick = 1'b0; key_req = 3'b000; play_en = 1'b0; vol_up = 1'b0; vol_dn = 1'b0;

    // Key priority, hold without preemption, release through IDLE, re-arbitration.
    add_vec(3'b110, 0, 0, 0, 0, RE,    4'b0010, 8, 0);
    add_vec(3'b111, 0, 0, 0, 0, RE,    4'b0010, 8, 0);
    add_vec(3'b101, 0, 0, 0, 0, 20'd0, 4'b0000, 8, 0);
    add_vec(3'b101, 0, 0, 0, 0, DO,    4'b0001, 8, 0);
    add_vec(3'b101, 0, 1, 0, 0, DO,    4'b0001, 8, 0);
    add_vec(3'b100, 0, 0, 0, 0, 20'd0, 4'b0000, 8, 0);
    add_vec(3'b100, 0, 0, 0, 0, MI,    4'b0100, 8, 0);
    add_vec(3'b000, 0, 0, 0, 0, 20'd0, 4'b0000, 8, 0);
    add_vec(3'b000, 0, 0, 0, 0, 20'd0, 4'b0000, 8, 0);
    // Volume saturation both ways.
    for (int i = 0; i < 10; i++) begin
      l = (9 + i > 15) ? 15 : 9 + i;
      add_vec(3'b000, 0, 0, 1, 0, 20'd0, 4'b0000, 4'(l), 0);
    end
    add_vec(3'b000, 0, 0, 1, 1, 20'd0, 4'b0000, 15, 0);
    for (int i = 0; i < 16; i++) begin
      l = (14 - i < 0) ? 0 : 14 - i;
      add_vec(3'b000, 0, 0, 0, 1, 20'd0, 4'b0000, 4'(l), 0);
    end
    add_vec(3'b000, 0, 0, 0, 0, 20'd0, 4'b0000, 0, 0);

    #12;
    check("reset_state", 20'd0, 4'b0000, 4'd8, 3'd0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].key, vecs[i].play, vecs[i].tk, vecs[i].up, vecs[i].dn);
      check($sformatf("vec%0d", i), vecs[i].div, vecs[i].gnt, vecs[i].lvl, vecs[i].stp);
    end
    exp_level = 4'd0;

    // Melody: full pass through all 8 steps including the rest and the wrap to 0.
    cyc(3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
    check("mel_start", DO, 4'b1000, exp_level, 3'd0);
    for (int s = 0; s < 8; s++) mel_step(s);
    mel_step(0);
    mel_step(1);

    // Preempt step 2 after one tick is consumed; resume must reload a full note.
    for (int c = 1; c <= 4; c++) begin
      cyc(3'b000, 1'b1, (c == 4), 1'b0, 1'b0);
      check($sformatf("pre_note_c%0d", c), MI, 4'b1000, exp_level, 3'd2);
    end
    for (int c = 1; c <= 10; c++) begin
      cyc(3'b001, 1'b1, (c % 4) == 0, 1'b0, 1'b0);
      check($sformatf("preempt_c%0d", c), DO, 4'b0001, exp_level, 3'd2);
    end
    cyc(3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
    check("release_idle", 20'd0, 4'b0000, exp_level, 3'd2);
    cyc(3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
    check("resume", MI, 4'b1000, exp_level, 3'd2);
    mel_step(2);

    // play_en drop mid-note clears step; coincident tick is ignored.
    cyc(3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
    check("play_off", 20'd0, 4'b0000, exp_level, 3'd0);
    cyc(3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    check("play_off_idle", 20'd0, 4'b0000, exp_level, 3'd0);

    // Async reset between edges during a note, then first arbitration on the next edge.
    cyc(3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
    check("mel_restart", DO, 4'b1000, exp_level, 3'd0);
    cyc(3'b000, 1'b1, 1'b1, 1'b0, 1'b0);
    check("mel_restart_tick", DO, 4'b1000, exp_level, 3'd0);
    #3;
    reset = 1'b1;
    #1;
    exp_level = 4'd8;
    check("async_reset", 20'd0, 4'b0000, exp_level, 3'd0);
    #3;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("first_arb", DO, 4'b1000, exp_level, 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
